// File: rtl/io_pkg.sv
// Shared constants and helpers for the board input conditioning path.
package io_pkg;

  localparam int unsigned NUM_SW          = 16;
  localparam int unsigned DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned PRESS_CNT_W     = 8;
  localparam int unsigned PRESS_CNT_MAX   = 255;

  // Button event state seen by the processor.
  typedef struct packed {
    logic                   sticky;
    logic [PRESS_CNT_W-1:0] count;
  } press_state_t;

  function automatic logic [PRESS_CNT_W-1:0] sat_inc(input logic [PRESS_CNT_W-1:0] v);
    return (v == PRESS_CNT_W'(PRESS_CNT_MAX)) ? v : v + PRESS_CNT_W'(1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: two-flop synchronizer followed by a stability counter that
// only accepts a new level after DEBOUNCE_CYCLES consecutive differing samples.
module debounce_channel #(
  parameter int unsigned DEBOUNCE_CYCLES = io_pkg::DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any sample agreeing with the accepted level restarts the count.
  always_comb begin
    s1_d     = raw;
    s2_d     = s1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (s2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/input_conditioner.sv
// Debounces slide switches and the right push-button, and tracks button presses
// (sticky flag plus saturating count) until the processor acknowledges them.
module input_conditioner #(
  parameter int unsigned NUM_SW          = io_pkg::NUM_SW,
  parameter int unsigned DEBOUNCE_CYCLES = io_pkg::DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_SW-1:0]              SW,
  input  logic                           BTNR,
  input  logic                           ack,
  output logic [NUM_SW-1:0]              sw_stable,
  output logic                           sw_changed,
  output logic                           btn_level,
  output logic                           btn_press,
  output logic                           btn_sticky,
  output logic [io_pkg::PRESS_CNT_W-1:0] press_count
);

  import io_pkg::*;

  localparam int unsigned NUM_CH = NUM_SW + 1;

  logic [NUM_CH-1:0] raw_vec;
  logic [NUM_CH-1:0] stable_vec;
  logic [NUM_CH-1:0] hist_q, hist_d;
  logic [NUM_SW-1:0] sw_q;
  logic              btn_q;
  press_state_t      press_q, press_d;

  // Button rides as the top channel so all inputs share one generate loop.
  assign raw_vec = {BTNR, SW};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_ch (
      .clock  (clock),
      .reset  (reset),
      .raw    (raw_vec[g]),
      .stable (stable_vec[g])
    );
  end

  assign sw_stable = stable_vec[NUM_SW-1:0];
  assign btn_level = stable_vec[NUM_SW];
  assign sw_q      = hist_q[NUM_SW-1:0];
  assign btn_q     = hist_q[NUM_SW];

  // Edge pulses compare the accepted levels against their one-cycle-old copies.
  assign btn_press  = btn_level & ~btn_q;
  assign sw_changed = |(sw_stable ^ sw_q);

  // A press arriving with ack starts a fresh event rather than being dropped.
  always_comb begin
    hist_d  = stable_vec;
    press_d = press_q;
    if (btn_press) begin
      press_d.sticky = 1'b1;
      press_d.count  = ack ? PRESS_CNT_W'(1) : sat_inc(press_q.count);
    end else if (ack) begin
      press_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist_q  <= '0;
      press_q <= '0;
    end else begin
      hist_q  <= hist_d;
      press_q <= press_d;
    end
  end

  assign btn_sticky  = press_q.sticky;
  assign press_count = press_q.count;

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner with a short debounce window.
module tb_input_conditioner;

  localparam int unsigned NSW = 16;
  localparam int unsigned DB  = 4;

  localparam int S_SW     = 0;
  localparam int S_SWCHG  = 1;
  localparam int S_LVL    = 2;
  localparam int S_PRESS  = 3;
  localparam int S_STICKY = 4;
  localparam int S_CNT    = 5;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic [NSW-1:0] sw    = '0;
  logic           btnr  = 1'b0;
  logic           ack   = 1'b0;

  logic [NSW-1:0] sw_stable;
  logic           sw_changed;
  logic           btn_level;
  logic           btn_press;
  logic           btn_sticky;
  logic [7:0]     press_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          cyc;
    int          sig;
    logic [15:0] val;
    string       tag;
  } exp_t;

  exp_t sb[$];

  input_conditioner #(
    .NUM_SW          (NSW),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clock       (clk),
    .reset       (rst_n),
    .SW          (sw),
    .BTNR        (btnr),
    .ack         (ack),
    .sw_stable   (sw_stable),
    .sw_changed  (sw_changed),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_sticky  (btn_sticky),
    .press_count (press_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_at(input int c, input int s, input logic [15:0] v, input string tag);
    exp_t e;
    e.cyc = c;
    e.sig = s;
    e.val = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  function automatic logic [15:0] obs(input int s);
    case (s)
      S_SW:     return sw_stable;
      S_SWCHG:  return {15'd0, sw_changed};
      S_LVL:    return {15'd0, btn_level};
      S_PRESS:  return {15'd0, btn_press};
      S_STICKY: return {15'd0, btn_sticky};
      S_CNT:    return {8'd0, press_count};
      default:  return 16'hDEAD;
    endcase
  endfunction

  // Compare every expectation due this cycle, mid-cycle away from the active edge.
  always @(negedge clk) begin
    for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check_eq(sb[i].tag, obs(sb[i].sig), sb[i].val);
        sb.delete(i);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ack();
    int a;
    a = cyc;
    expect_at(a + 1, S_STICKY, 16'd0, "ack_sticky");
    expect_at(a + 1, S_CNT,    16'd0, "ack_count");
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    step(1);
  endtask

  // Qualified press: level at k+6, pulse at k+6 only, sticky/count at k+7.
  task automatic do_press(input bit ack_sim, input int exp_cnt, input string tag);
    int k;
    k = cyc;
    btnr = 1'b1;
    expect_at(k + 5, S_PRESS,  16'd0,            {tag, "_pre"});
    expect_at(k + 6, S_PRESS,  16'd1,            {tag, "_pulse"});
    expect_at(k + 7, S_PRESS,  16'd0,            {tag, "_pulse_end"});
    expect_at(k + 7, S_STICKY, 16'd1,            {tag, "_sticky"});
    expect_at(k + 7, S_CNT,    16'(exp_cnt),     {tag, "_count"});
    step(6);
    if (ack_sim) ack = 1'b1;
    step(1);
    ack = 1'b0;
    step(1);
    btnr = 1'b0;
    step(8);
  endtask

  initial begin
    int k;
    int m;
    int r;

    // Reset with every input high.
    sw    = '1;
    btnr  = 1'b1;
    rst_n = 1'b0;
    for (int s = 0; s < 6; s++) begin
      expect_at(2, s, 16'd0, "rst_hold");
      expect_at(4, s, 16'd0, "rst_first_edge");
    end
    step(3);
    rst_n = 1'b1;
    expect_at(8,  S_SW,     16'h0000, "rst_sw_early");
    expect_at(8,  S_SWCHG,  16'd0,    "rst_swchg_early");
    expect_at(8,  S_LVL,    16'd0,    "rst_btn_early");
    expect_at(9,  S_SW,     16'hFFFF, "rst_sw_qual");
    expect_at(9,  S_SWCHG,  16'd1,    "rst_swchg_pulse");
    expect_at(9,  S_LVL,    16'd1,    "rst_btn_qual");
    expect_at(9,  S_PRESS,  16'd1,    "rst_btn_press");
    expect_at(9,  S_STICKY, 16'd0,    "rst_sticky_late");
    expect_at(10, S_SWCHG,  16'd0,    "rst_swchg_end");
    expect_at(10, S_PRESS,  16'd0,    "rst_press_end");
    expect_at(10, S_STICKY, 16'd1,    "rst_sticky");
    expect_at(10, S_CNT,    16'd1,    "rst_count");
    step(9);
    btnr = 1'b0;
    step(8);
    pulse_ack();

    // Three-cycle glitch must not qualify.
    k = cyc;
    btnr = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      expect_at(k + c, S_LVL,    16'd0, "glitch_level");
      expect_at(k + c, S_PRESS,  16'd0, "glitch_press");
      expect_at(k + c, S_STICKY, 16'd0, "glitch_sticky");
    end
    step(3);
    btnr = 1'b0;
    step(12);

    // Clean 20-cycle press and its release.
    k = cyc;
    btnr = 1'b1;
    expect_at(k + 5, S_LVL,    16'd0, "clean_level_early");
    expect_at(k + 5, S_PRESS,  16'd0, "clean_press_early");
    expect_at(k + 6, S_LVL,    16'd1, "clean_level");
    expect_at(k + 6, S_PRESS,  16'd1, "clean_press");
    expect_at(k + 6, S_STICKY, 16'd0, "clean_sticky_early");
    expect_at(k + 7, S_PRESS,  16'd0, "clean_press_end");
    expect_at(k + 7, S_STICKY, 16'd1, "clean_sticky");
    expect_at(k + 7, S_CNT,    16'd1, "clean_count");
    for (int c = 8; c < 20; c++) expect_at(k + c, S_PRESS, 16'd0, "clean_hold_nopulse");
    step(20);
    btnr = 1'b0;
    k = cyc;
    for (int c = 0; c <= 10; c++) expect_at(k + c, S_PRESS, 16'd0, "release_nopulse");
    expect_at(k + 5,  S_LVL,    16'd1, "release_level_early");
    expect_at(k + 6,  S_LVL,    16'd0, "release_level");
    expect_at(k + 10, S_STICKY, 16'd1, "release_sticky_kept");
    expect_at(k + 10, S_CNT,    16'd1, "release_count_kept");
    step(12);

    // Saturation at 255, then ack.
    pulse_ack();
    for (int n = 1; n <= 300; n++) begin
      do_press(1'b0, (n > 255) ? 255 : n, $sformatf("sat%0d", n));
    end
    pulse_ack();

    // Ack coinciding with a press keeps the new event.
    do_press(1'b0, 1, "pre1");
    do_press(1'b0, 2, "pre2");
    do_press(1'b1, 1, "simul");

    // Several switches change together; one OR pulse, button untouched.
    k = cyc;
    sw = 16'h0F0F;
    expect_at(k + 5, S_SW,    16'hFFFF, "sw_multi_early");
    expect_at(k + 5, S_SWCHG, 16'd0,    "sw_multi_chg_early");
    expect_at(k + 6, S_SW,    16'h0F0F, "sw_multi");
    expect_at(k + 6, S_SWCHG, 16'd1,    "sw_multi_chg");
    expect_at(k + 6, S_PRESS, 16'd0,    "sw_multi_nobtn");
    expect_at(k + 7, S_SWCHG, 16'd0,    "sw_multi_chg_end");
    step(10);
    k = cyc;
    sw = 16'h0000;
    expect_at(k + 6, S_SW,    16'h0000, "sw_release");
    expect_at(k + 6, S_SWCHG, 16'd1,    "sw_release_chg");
    expect_at(k + 7, S_SWCHG, 16'd0,    "sw_release_chg_end");
    step(10);

    // Reset in the middle of a qualifying count.
    m = cyc;
    sw = 16'h0008;
    expect_at(m + 4, S_SW, 16'h0000, "midrst_pre");
    step(4);
    rst_n = 1'b0;
    for (int s = 0; s < 6; s++) expect_at(m + 5, s, 16'd0, "midrst_in_reset");
    expect_at(m + 6, S_SW, 16'h0000, "midrst_no_qual");
    step(2);
    rst_n = 1'b1;
    r = cyc;
    expect_at(r + 5, S_SW,    16'h0000, "midrst_requal_early");
    expect_at(r + 6, S_SW,    16'h0008, "midrst_requal");
    expect_at(r + 6, S_SWCHG, 16'd1,    "midrst_requal_chg");
    step(10);

    step(5);
    check_eq("sb_drain", 16'(sb.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
